// File: rtl/seg_pkg.sv
// Shared constants and types for the 4-digit 7-segment scan driver.
// Glyphs are active-low, bit order g..a (bit 0 = segment a).
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] ANODE_OFF = 4'b1111;

  typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to active-low glyph; 10..15 render as a dash.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // glyph lookup; out-of-range values flag as a dash rather than garbage
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_display_mux.sv
// Time-multiplexed 4-digit common-anode 7-segment driver for an MM:SS word.
// Frame snapshot avoids tearing, each slot opens with anti-ghost dead time,
// and the digit-3 decimal point separates minutes from seconds.
// Optional whole-frame blinking is built when SEG_DISPLAY_BLINK_EN is defined.
module seg_display_mux
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int DEAD_CYCLES  = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic [16:1] digits_in,
  input  logic        blank_lead,
  input  logic        blink_req,
  output logic [7:1]  seg,
  output logic        dp,
  output logic [4:1]  an
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CW-1:0] refresh_cnt;
  digit_idx_t    idx;
  logic [15:0]   snap;
  logic          slot_end, frame_end, dead;
  logic [3:0]    nibble;
  logic [6:0]    glyph;
  logic          blink_hold;
  logic [3:0]    an_d;
  logic [6:0]    seg_d;
  logic          dp_d;

  assign slot_end  = (refresh_cnt == CW'(REFRESH_DIV - 1));
  assign frame_end = slot_end && (idx == 2'd3);
  assign dead      = (refresh_cnt < CW'(DEAD_CYCLES));
  assign nibble    = snap[{idx, 2'b00} +: 4];

  // slot timer, digit index and frame snapshot (loaded only at frame boundary)
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      refresh_cnt <= '0;
      idx         <= '0;
      snap        <= '0;
    end else begin
      if (slot_end) begin
        refresh_cnt <= '0;
        idx         <= idx + 2'd1;
      end else begin
        refresh_cnt <= refresh_cnt + CW'(1);
      end
      if (frame_end) snap <= digits_in;
    end
  end

  bcd_to_seg u_dec (
    .bcd (nibble),
    .seg (glyph)
  );

`ifdef SEG_DISPLAY_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FW-1:0] frame_cnt;
  logic          blink_phase, phase_nxt, slot_blank;

  assign phase_nxt  = (frame_end && frame_cnt == FW'(BLINK_FRAMES - 1)) ? ~blink_phase : blink_phase;
  assign blink_hold = slot_blank;

  // frame counter and blink phase; blank decision is latched per slot so a
  // deasserted request takes effect at the next slot, never mid-slot
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      slot_blank  <= 1'b0;
    end else begin
      if (frame_end)
        frame_cnt <= (frame_cnt == FW'(BLINK_FRAMES - 1)) ? '0 : frame_cnt + FW'(1);
      blink_phase <= phase_nxt;
      if (slot_end) slot_blank <= blink_req && phase_nxt;
    end
  end
`else
  logic unused_blink_req;
  assign unused_blink_req = blink_req;
  assign blink_hold       = 1'b0;
`endif

  // next output pattern from the current (pre-edge) scan state
  always_comb begin
    an_d  = ANODE_OFF;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (!dead && !blink_hold) begin
      an_d  = ~(4'b0001 << idx);
      seg_d = (blank_lead && idx == 2'd3 && nibble == 4'd0) ? SEG_BLANK : glyph;
      dp_d  = (idx != 2'd2);
    end
  end

  // registered outputs, forced blank asynchronously by reset
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      an  <= ANODE_OFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= an_d;
      seg <= seg_d;
      dp  <= dp_d;
    end
  end

endmodule

// File: tb/tb_seg_display_mux.sv
// Bench for seg_display_mux: directed sequence plus random words, checked
// every cycle against a frame/slot reference computed from elapsed cycles.
module tb_seg_display_mux;

  localparam int DIV  = 8;
  localparam int DEAD = 1;
  localparam int BF   = 2;
  localparam int FRM  = 4 * DIV;
`ifdef SEG_DISPLAY_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        RESET = 1'b1;
  logic [16:1] digits_in = '0;
  logic        blank_lead = 1'b0;
  logic        blink_req = 1'b0;
  logic [7:1]  seg;
  logic        dp;
  logic [4:1]  an;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int j = 0;
  bit blink_on = 1'b0;
  logic [15:0] din_hist [0:4095];
  bit          bl_hist  [0:4095];

  seg_display_mux #(.REFRESH_DIV(DIV), .DEAD_CYCLES(DEAD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .RESET(RESET), .digits_in(digits_in), .blank_lead(blank_lead),
    .blink_req(blink_req), .seg(seg), .dp(dp), .an(an)
  );

  always #5 clk = ~clk;

  // glyph built from the list of lit segment letters
  function automatic logic [6:0] glyph(input int n);
    string s;
    logic [6:0] lit;
    lit = '0;
    case (n)
      0: s = "abcdef";  1: s = "bc";      2: s = "abdeg";  3: s = "abcdg";
      4: s = "bcfg";    5: s = "acdfg";   6: s = "acdefg"; 7: s = "abc";
      8: s = "abcdefg"; 9: s = "abcdfg";  default: s = "g";
    endcase
    for (int i = 0; i < s.len(); i++) lit[int'(s.getc(i)) - 97] = 1'b1;
    return ~lit;
  endfunction

  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
    cmp_cnt++;
    assert (got === exp) else begin
      err_cnt++;
      $error("FAIL %s at cycle %0d: got %b expected %b", tag, j, got, exp);
    end
  endtask

  task automatic chk_blank(input string tag);
    chk({tag, "_an"},  {3'b0, an},  7'h0F);
    chk({tag, "_seg"}, seg,         7'h7F);
    chk({tag, "_dp"},  {6'b0, dp},  7'h01);
  endtask

  // expected outputs after edge number e since reset release
  task automatic check_cycle(input int e);
    int cnt, idx, f, nib;
    logic [15:0] word;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic e_dp;
    cnt  = e % DIV;
    idx  = (e / DIV) % 4;
    f    = e / FRM;
    word = (f == 0) ? 16'h0000 : din_hist[FRM * f - 1];
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    if (!(cnt < DEAD) && !(BLINK && blink_on && ((f / BF) % 2 == 1))) begin
      nib = int'((word >> (4 * idx)) & 16'hF);
      e_an[idx] = 1'b0;
      e_seg = (bl_hist[e] && idx == 3 && nib == 0) ? 7'h7F : glyph(nib);
      e_dp  = (idx != 2);
    end
    chk("an",  {3'b0, an}, {3'b0, e_an});
    chk("seg", seg,        e_seg);
    chk("dp",  {6'b0, dp}, {6'b0, e_dp});
  endtask

  task automatic tick();
    @(posedge clk);
    din_hist[j] = digits_in;
    bl_hist[j]  = blank_lead;
    @(negedge clk);
    check_cycle(j);
    j++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic release_reset();
    @(negedge clk);
    chk_blank("rst_hold");
    RESET = 1'b0;
    j = 0;
  endtask

  initial begin
    // reset state with a live input word
    digits_in = 16'h1234;
    repeat (2) @(negedge clk);
    chk_blank("rst");
    release_reset();
    // frame 0 shows 0000, frame 1 shows 1234
    run(FRM);
    digits_in = 16'h0259;
    run(FRM + 10);
    // change during digit-2 slot of the 0259 frame
    digits_in = 16'h0300;
    run(2 * FRM - 10);
    // leading blank and illegal nibble
    digits_in  = 16'h0A05;
    blank_lead = 1'b1;
    run(2 * FRM);
    blank_lead = 1'b0;
    digits_in  = 16'h0012;
    run(FRM);
    blank_lead = 1'b1;
    run(2 * FRM);
    // random words and blank_lead toggling
    for (int i = 0; i < 20 * FRM; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        for (int k = 0; k < 4; k++)
          digits_in[4*k+1 +: 4] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 49) == 0) blank_lead = ~blank_lead;
      tick();
    end
    // async reset in the digit-3 slot, between edges
    while ((j % FRM) != 2 * DIV + 3) tick();
    #2 RESET = 1'b1;
    #1 chk_blank("async_rst");
    release_reset();
    digits_in  = 16'h5907;
    blank_lead = 1'b0;
    run(2 * FRM);
    // blinking request held for several frames
    RESET = 1'b1;
    blink_req = 1'b1;
    blink_on  = 1'b1;
    digits_in = 16'h4321;
    release_reset();
    run(8 * FRM);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
